// File: rtl/multi_sample_hold.sv
// Multi-channel windowed sampler: per-window SAMPLE, MEAN or MAX of each
// channel, one shared window counter, held result with a valid strobe.
// Ports: clk; rst_n (async, active-low); sync (force window end);
//   period_log2 (window = 2^n clocks, clamped); mode (0 SAMPLE, 1 MEAN,
//   2 MAX, 3 SAMPLE); hold (freeze dout); din/dout (CHANNELS x WIDTH,
//   channel c at [c*WIDTH +: WIDTH]); dout_valid (one-cycle update pulse).
module multi_sample_hold #(
    parameter  int WIDTH       = 8,
    parameter  int CHANNELS    = 4,
    parameter  int MAX_PERIOD  = 128,
    localparam int PERIOD_BITS = $clog2(MAX_PERIOD),
    localparam int PL_BITS     = $clog2(PERIOD_BITS + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sync,
    input  logic [PL_BITS-1:0]        period_log2,
    input  logic [1:0]                mode,
    input  logic                      hold,
    input  logic [CHANNELS*WIDTH-1:0] din,
    output logic [CHANNELS*WIDTH-1:0] dout,
    output logic                      dout_valid
);

    localparam int AW = WIDTH + PERIOD_BITS;
    localparam logic [PERIOD_BITS:0] ONE = (PERIOD_BITS + 1)'(1);

    typedef enum logic [1:0] {
        M_SAMPLE = 2'd0,
        M_MEAN   = 2'd1,
        M_MAX    = 2'd2,
        M_RSVD   = 2'd3
    } mode_t;

    logic [PERIOD_BITS-1:0] ctr;
    logic [PERIOD_BITS-1:0] ctr_last;
    logic [PL_BITS-1:0]     pl_in;
    logic [PL_BITS-1:0]     pl_act;
    logic [PL_BITS-1:0]     pl_cur;
    logic [PL_BITS-1:0]     pl_res;
    mode_t                  mode_act;
    mode_t                  mode_res;
    logic                   fresh;
    logic                   e;
    logic                   e_d;
    logic                   upd;

    assign pl_in = (period_log2 > PL_BITS'(PERIOD_BITS))
                 ? PL_BITS'(PERIOD_BITS) : period_log2;

    // Right after reset the shadow period has not been loaded yet, so the
    // first window follows the live (clamped) input until the first edge.
    assign pl_cur   = fresh ? pl_in : pl_act;
    assign ctr_last = PERIOD_BITS'((ONE << pl_cur) - ONE);
    assign e        = sync | (ctr == ctr_last);
    assign upd      = e_d & ~hold;

    // mode_res/pl_res keep the closing window's config for the e_d cycle,
    // since the active shadows already hold the next window's config then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr        <= '0;
            e_d        <= 1'b0;
            fresh      <= 1'b1;
            pl_act     <= '0;
            pl_res     <= '0;
            mode_act   <= M_SAMPLE;
            mode_res   <= M_SAMPLE;
            dout_valid <= 1'b0;
        end else begin
            fresh      <= 1'b0;
            e_d        <= e;
            dout_valid <= upd;
            if (e) begin
                ctr      <= '0;
                mode_act <= mode_t'(mode);
                pl_act   <= pl_in;
                mode_res <= mode_act;
                pl_res   <= pl_cur;
            end else begin
                ctr <= ctr + PERIOD_BITS'(1);
                if (fresh) begin
                    pl_act <= pl_in;
                end
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] mx;
        logic [WIDTH-1:0] mx_nx;
        logic [WIDTH-1:0] mean;
        logic [WIDTH-1:0] q;
        logic [AW-1:0]    acc;
        logic [AW-1:0]    sum_nx;
        logic [AW-1:0]    res;

        assign x      = din[c*WIDTH +: WIDTH];
        assign sum_nx = acc + AW'(x);
        assign mx_nx  = (x > mx) ? x : mx;
        assign mean   = WIDTH'(res >> pl_res);

        // The e-cycle sample is folded into res as the window closes, so
        // acc/mx can restart cleanly with the next window's first sample.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc <= '0;
                mx  <= '0;
                res <= '0;
                q   <= '0;
            end else begin
                if (e) begin
                    acc <= '0;
                    mx  <= '0;
                    res <= (mode_act == M_MAX) ? AW'(mx_nx) : sum_nx;
                end else begin
                    acc <= sum_nx;
                    mx  <= mx_nx;
                end
                if (upd) begin
                    unique case (1'b1)
                        mode_res == M_MEAN: q <= mean;
                        mode_res == M_MAX:  q <= res[WIDTH-1:0];
                        default:            q <= x;
                    endcase
                end
            end
        end

        assign dout[c*WIDTH +: WIDTH] = q;
    end

endmodule

// File: tb/tb_multi_sample_hold.sv
// Directed + randomized bench for multi_sample_hold with a queue-based
// window model; every cycle dout/dout_valid are compared with the model.
module tb_multi_sample_hold;

    localparam int W   = 8;
    localparam int CH  = 2;
    localparam int MP  = 128;
    localparam int PLB = 3;

    typedef logic [CH*W-1:0] vec_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           sync;
    logic           hold;
    logic [1:0]     mode;
    logic [PLB-1:0] period_log2;
    vec_t           din;
    vec_t           dout;
    logic           dout_valid;

    int checks   = 0;
    int failures = 0;

    vec_t win[$];
    vec_t pend_win[$];
    int   mdl_mode;
    int   mdl_pl;
    int   pend_mode;
    int   pend_pl;
    bit   pend;
    vec_t exp_dout;
    logic exp_valid;
    int   nval;
    vec_t last;

    multi_sample_hold #(
        .WIDTH(W),
        .CHANNELS(CH),
        .MAX_PERIOD(MP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sync(sync),
        .period_log2(period_log2),
        .mode(mode),
        .hold(hold),
        .din(din),
        .dout(dout),
        .dout_valid(dout_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        win.delete();
        pend_win.delete();
        pend      = 1'b0;
        exp_dout  = '0;
        exp_valid = 1'b0;
        mdl_mode  = 0;
        mdl_pl    = (int'(period_log2) > 7) ? 7 : int'(period_log2);
    endtask

    // One clock edge of the reference: window = list of samples since the
    // last window end; result is published in the following cycle.
    task automatic model_edge();
        int acc;
        int mx;
        int v;
        if (!rst_n) begin
            model_reset();
            return;
        end
        win.push_back(din);
        exp_valid = 1'b0;
        if (pend && !hold) begin
            exp_valid = 1'b1;
            for (int c = 0; c < CH; c++) begin
                acc = 0;
                mx  = 0;
                foreach (pend_win[i]) begin
                    v   = int'(pend_win[i][c*W +: W]);
                    acc = acc + v;
                    if (v > mx) mx = v;
                end
                case (pend_mode)
                    1:       exp_dout[c*W +: W] = W'(acc >> pend_pl);
                    2:       exp_dout[c*W +: W] = W'(mx);
                    default: exp_dout[c*W +: W] = din[c*W +: W];
                endcase
            end
        end
        pend = 1'b0;
        if (sync || win.size() == (1 << mdl_pl)) begin
            pend      = 1'b1;
            pend_win  = win;
            pend_mode = mdl_mode;
            pend_pl   = mdl_pl;
            win.delete();
            mdl_mode  = int'(mode);
            mdl_pl    = (int'(period_log2) > 7) ? 7 : int'(period_log2);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("dout", 32'(dout), 32'(exp_dout));
        chk("dout_valid", 32'(dout_valid), 32'(exp_valid));
    endtask

    task automatic sync_cfg(input logic [1:0] m, input logic [PLB-1:0] p);
        mode        = m;
        period_log2 = p;
        din         = vec_t'($urandom);
        sync        = 1'b1;
        step();
        sync        = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        sync        = 1'b0;
        hold        = 1'b0;
        mode        = 2'd0;
        period_log2 = 3'd2;
        din         = '0;
        #12;
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_valid", 32'(dout_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // SAMPLE, P=4: ch0 = cycle count, ch1 = 0xFF
        nval = 0;
        last = '0;
        for (int k = 0; k < 16; k++) begin
            din = {8'hFF, 8'(k)};
            step();
            if (dout_valid) begin
                nval++;
                last = dout;
            end
        end
        chk("samp_npulse", 32'(nval), 32'd3);
        chk("samp_ch0", 32'(last[7:0]), 32'd12);
        chk("samp_ch1", 32'(last[15:8]), 32'hFF);

        // MEAN, P=8, ch0 = 0..7
        sync_cfg(2'd1, 3'd3);
        for (int k = 0; k < 8; k++) begin
            din = {8'($urandom), 8'(k)};
            step();
        end
        din = vec_t'($urandom);
        step();
        chk("mean8_ch0", 32'(dout[7:0]), 32'd3);
        chk("mean8_valid", 32'(dout_valid), 32'd1);

        // MEAN, P=128, all 0xFF
        sync_cfg(2'd1, 3'd7);
        din = 16'hFFFF;
        for (int k = 0; k < 128; k++) step();
        step();
        chk("mean128", 32'(dout), 32'hFFFF);

        // MAX, P=16: peak 0xA5 then a window peaking at 0x10
        sync_cfg(2'd2, 3'd4);
        for (int k = 0; k < 16; k++) begin
            din = {(k == 5) ? 8'hA5 : 8'($urandom_range(0, 8'hA4)),
                   8'($urandom)};
            step();
        end
        for (int k = 0; k < 16; k++) begin
            din = {(k == 3) ? 8'h10 : 8'($urandom_range(0, 8'h10)),
                   8'($urandom)};
            step();
            if (k == 0) chk("max_a5", 32'(dout[15:8]), 32'hA5);
        end
        din = vec_t'($urandom);
        step();
        chk("max_10", 32'(dout[15:8]), 32'h10);

        // sync truncates a MEAN P=8 window to 3 cycles
        sync_cfg(2'd1, 3'd3);
        din = 16'h0808;
        step();
        step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        step();
        chk("trunc_mean", 32'(dout[7:0]), 32'd3);
        for (int k = 0; k < 7; k++) step();
        step();
        chk("trunc_next", 32'(dout[7:0]), 32'd8);
        chk("trunc_nvalid", 32'(dout_valid), 32'd1);

        // mid-window config change, then hold at e_d
        sync_cfg(2'd1, 3'd3);
        for (int k = 0; k < 8; k++) begin
            if (k == 3) begin
                mode        = 2'd2;
                period_log2 = 3'd2;
            end
            din = {8'($urandom), 8'(2 * k)};
            step();
        end
        din = vec_t'($urandom);
        step();
        chk("oldcfg_mean", 32'(dout[7:0]), 32'd7);
        for (int k = 0; k < 3; k++) begin
            din = vec_t'($urandom);
            step();
        end
        hold = 1'b1;
        step();
        hold = 1'b0;
        chk("hold_dout", 32'(dout[7:0]), 32'd7);
        chk("hold_valid", 32'(dout_valid), 32'd0);

        // P=1: update every cycle
        sync_cfg(2'd1, 3'd0);
        for (int k = 0; k < 10; k++) begin
            din = vec_t'($urandom);
            step();
        end

        // back-to-back sync: windows of one cycle
        sync_cfg(2'd1, 3'd3);
        sync = 1'b1;
        din  = 16'h4040;
        step();
        din  = vec_t'($urandom);
        step();
        chk("sync1_mean", 32'(dout[7:0]), 32'd8);
        for (int k = 0; k < 4; k++) begin
            din = vec_t'($urandom);
            step();
        end
        sync = 1'b0;

        // async reset mid-window in MEAN
        sync_cfg(2'd1, 3'd3);
        din = 16'hFFFF;
        for (int k = 0; k < 3; k++) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_dout", 32'(dout), 32'h0);
        chk("arst_valid", 32'(dout_valid), 32'h0);
        model_reset();
        step();
        rst_n = 1'b1;
        model_reset();
        din = 16'h0404;
        for (int k = 0; k < 8; k++) step();
        step();
        chk("post_rst_samp", 32'(dout[7:0]), 32'd4);
        for (int k = 0; k < 7; k++) step();
        step();
        chk("post_rst_mean", 32'(dout[7:0]), 32'd4);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if (i % 25 == 0) begin
                mode        = 2'($urandom_range(0, 3));
                period_log2 = PLB'($urandom_range(0, 5));
            end
            din  = vec_t'($urandom);
            sync = ($urandom_range(0, 9) == 0);
            hold = ($urandom_range(0, 4) == 0);
            step();
        end
        sync = 1'b0;
        hold = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
